// File: rtl/background_sweeper.sv
// Raster sweeper: walks every (x, y) into the background lookup, re-aligns each
// coordinate with the registered colour one clock later and drives the VGA plot port.
module background_sweeper #(
    parameter int X_MAX = 319,
    parameter int Y_MAX = 239
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic [2:0] colour_in,
    output logic [8:0] x_cord,
    output logic [8:0] y_cord,
    output logic [8:0] x_out,
    output logic [8:0] y_out,
    output logic [2:0] colour_out,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam logic [8:0] X_LAST = 9'(X_MAX);
    localparam logic [8:0] Y_LAST = 9'(Y_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state_reg, state_next;
    logic [8:0] cnt_x_reg, cnt_x_next;
    logic [8:0] cnt_y_reg, cnt_y_next;
    logic [8:0] d_x_reg, d_y_reg;
    logic       d_valid_reg;

    logic issue;
    logic at_last;

    assign issue   = (state_reg == SWEEP) && !pause;
    assign at_last = (cnt_x_reg == X_LAST) && (cnt_y_reg == Y_LAST);

    always_comb begin
        state_next = state_reg;
        cnt_x_next = cnt_x_reg;
        cnt_y_next = cnt_y_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SWEEP;
                    cnt_x_next = '0;
                    cnt_y_next = '0;
                end
            end
            SWEEP: begin
                if (issue) begin
                    if (at_last) begin
                        state_next = FLUSH;
                        cnt_x_next = '0;
                        cnt_y_next = '0;
                    end else if (cnt_x_reg == X_LAST) begin
                        cnt_x_next = '0;
                        cnt_y_next = cnt_y_reg + 9'd1;
                    end else begin
                        cnt_x_next = cnt_x_reg + 9'd1;
                    end
                end
            end
            FLUSH:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The delayed coordinate lines up with the colour the lookup registers on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_x_reg   <= '0;
            cnt_y_reg   <= '0;
            d_x_reg     <= '0;
            d_y_reg     <= '0;
            d_valid_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_x_reg   <= cnt_x_next;
            cnt_y_reg   <= cnt_y_next;
            d_x_reg     <= cnt_x_reg;
            d_y_reg     <= cnt_y_reg;
            d_valid_reg <= issue;
        end
    end

    assign x_cord     = cnt_x_reg;
    assign y_cord     = cnt_y_reg;
    assign x_out      = d_x_reg;
    assign y_out      = d_y_reg;
    assign plot       = d_valid_reg;
    assign colour_out = colour_in;
    assign busy       = (state_reg == SWEEP) || (state_reg == FLUSH);
    assign done       = (state_reg == DONE);

endmodule

// File: tb/tb_background_sweeper.sv
// Directed bench for background_sweeper: a 16x8 sweeper exercises pause, restart and
// reset cases, and a 4x2 sweeper checks the exact plot order and done latency.
module tb_background_sweeper;

    localparam int XM1 = 15;
    localparam int YM1 = 7;
    localparam int N1  = (XM1 + 1) * (YM1 + 1);
    localparam int XM2 = 3;
    localparam int YM2 = 1;
    localparam int N2  = (XM2 + 1) * (YM2 + 1);

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start1 = 1'b0, pause1 = 1'b0;
    logic       start2 = 1'b0, pause2 = 1'b0;
    logic [2:0] col1, col2;
    logic [8:0] x_cord1, y_cord1, x_out1, y_out1;
    logic [8:0] x_cord2, y_cord2, x_out2, y_out2;
    logic [2:0] colour_out1, colour_out2;
    logic       plot1, busy1, done1, plot2, busy2, done2;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    int q1x[$], q1y[$], q1c[$], q1t[$];
    int q2x[$], q2y[$], q2c[$], q2t[$];

    background_sweeper #(.X_MAX(XM1), .Y_MAX(YM1)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .pause(pause1), .colour_in(col1),
        .x_cord(x_cord1), .y_cord(y_cord1), .x_out(x_out1), .y_out(y_out1),
        .colour_out(colour_out1), .plot(plot1), .busy(busy1), .done(done1)
    );

    background_sweeper #(.X_MAX(XM2), .Y_MAX(YM2)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .pause(pause2), .colour_in(col2),
        .x_cord(x_cord2), .y_cord(y_cord2), .x_out(x_out2), .y_out(y_out2),
        .colour_out(colour_out2), .plot(plot2), .busy(busy2), .done(done2)
    );

    always #5 clock = ~clock;

    function automatic logic [2:0] lut(input int x, input int y);
        logic [2:0] xs, ys;
        xs = 3'(x);
        ys = 3'(y);
        return 3'b111 ^ (xs + ys);
    endfunction

    // Background lookup stand-in: registered colour, one clock after the coordinate.
    always @(posedge clock) begin
        cyc  <= cyc + 1;
        col1 <= lut(int'(x_cord1), int'(y_cord1));
        col2 <= lut(int'(x_cord2), int'(y_cord2));
    end

    always @(negedge clock) begin
        if (plot1) begin
            q1x.push_back(int'(x_out1)); q1y.push_back(int'(y_out1));
            q1c.push_back(int'(colour_out1)); q1t.push_back(cyc);
        end
        if (plot2) begin
            q2x.push_back(int'(x_out2)); q2y.push_back(int'(y_out2));
            q2c.push_back(int'(colour_out2)); q2t.push_back(cyc);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, actual, actual, expected, expected);
        end
    endtask

    task automatic clear_q1();
        q1x.delete(); q1y.delete(); q1c.delete(); q1t.delete();
    endtask

    task automatic start_main(output int s);
        @(posedge clock); #1 start1 = 1'b1;
        @(posedge clock); #1 s = cyc; start1 = 1'b0;
    endtask

    task automatic wait_xy1(input string tag, input int x, input int y);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clock);
            if (busy1 && int'(x_cord1) == x && int'(y_cord1) == y) found = 1'b1;
        end
        check_val({tag, "_reached"}, 32'(found), 32'd1);
    endtask

    // Waits for done on dut1; optionally raises start during the DONE cycle.
    task automatic wait_done1(input string tag, input bit start_in_done, output int dc);
        bit found;
        found = 1'b0;
        dc    = -1;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clock);
            if (done1) begin
                found = 1'b1;
                dc    = cyc;
            end
        end
        check_val({tag, "_done_seen"}, 32'(found), 32'd1);
        if (start_in_done) start1 = 1'b1;
        @(negedge clock);
        start1 = 1'b0;
        check_val({tag, "_done_width"}, 32'(done1), 32'd0);
        check_val({tag, "_busy_after"}, 32'(busy1), 32'd0);
    endtask

    task automatic check_frame1(input string tag, input int s);
        check_val({tag, "_count"}, 32'(q1x.size()), 32'(N1));
        if (q1t.size() > 0) check_val({tag, "_first_plot_cyc"}, 32'(q1t[0] - s), 32'd1);
        for (int i = 0; i < q1x.size() && i < N1; i++) begin
            check_val($sformatf("%s_x[%0d]", tag, i), 32'(q1x[i]), 32'(i % (XM1 + 1)));
            check_val($sformatf("%s_y[%0d]", tag, i), 32'(q1y[i]), 32'(i / (XM1 + 1)));
            check_val($sformatf("%s_c[%0d]", tag, i), 32'(q1c[i]),
                      32'(lut(i % (XM1 + 1), i / (XM1 + 1))));
        end
    endtask

    initial begin
        int s, dc, found2;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_val("rst_plot",   32'(plot1),   32'd0);
        check_val("rst_busy",   32'(busy1),   32'd0);
        check_val("rst_done",   32'(done1),   32'd0);
        check_val("rst_x_cord", 32'(x_cord1), 32'd0);
        check_val("rst_y_cord", 32'(y_cord1), 32'd0);
        check_val("rst_x_out",  32'(x_out1),  32'd0);
        check_val("rst_y_out",  32'(y_out1),  32'd0);
        check_val("rst_colour", 32'(colour_out1), 32'(lut(0, 0)));
        check_val("rst_plot2",  32'(plot2),   32'd0);
        $display("[TB] reset state checked");

        // Plain frame.
        clear_q1();
        start_main(s);
        wait_done1("plain", 1'b0, dc);
        check_val("plain_done_cyc", 32'(dc - s), 32'(N1 + 1));
        check_frame1("plain", s);
        $display("[TB] plain frame: %0d plots, done %0d cycles after start", q1x.size(), dc - s);

        // Pause for 5 cycles at (5,2).
        clear_q1();
        start_main(s);
        wait_xy1("pause", 5, 2);
        pause1 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check_val($sformatf("pause_plot[%0d]", k), 32'(plot1), 32'd0);
            check_val($sformatf("pause_x_out[%0d]", k), 32'(x_out1), 32'd5);
            check_val($sformatf("pause_y_out[%0d]", k), 32'(y_out1), 32'd2);
            check_val($sformatf("pause_x_cord[%0d]", k), 32'(x_cord1), 32'd5);
        end
        pause1 = 1'b0;
        wait_done1("pause", 1'b0, dc);
        check_val("pause_done_cyc", 32'(dc - s), 32'(N1 + 1 + 5));
        check_frame1("pause", s);
        $display("[TB] paused frame: %0d plots, done %0d cycles after start", q1x.size(), dc - s);

        // Start re-asserted mid-sweep and during DONE.
        clear_q1();
        start_main(s);
        repeat (20) @(negedge clock);
        start1 = 1'b1;
        @(negedge clock);
        start1 = 1'b0;
        wait_done1("restart", 1'b1, dc);
        check_val("restart_done_cyc", 32'(dc - s), 32'(N1 + 1));
        repeat (5) @(negedge clock);
        check_val("restart_idle_busy", 32'(busy1), 32'd0);
        check_frame1("restart", s);
        $display("[TB] start-ignored frame: %0d plots", q1x.size());

        // Reset mid-sweep at (9,4), then a fresh frame.
        clear_q1();
        start_main(s);
        wait_xy1("rstmid", 9, 4);
        reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check_val("rstmid_plot",   32'(plot1),   32'd0);
        check_val("rstmid_busy",   32'(busy1),   32'd0);
        check_val("rstmid_done",   32'(done1),   32'd0);
        check_val("rstmid_x_cord", 32'(x_cord1), 32'd0);
        check_val("rstmid_y_cord", 32'(y_cord1), 32'd0);
        check_val("rstmid_x_out",  32'(x_out1),  32'd0);
        check_val("rstmid_y_out",  32'(y_out1),  32'd0);
        repeat (3) @(negedge clock);
        check_val("rstmid_stays_idle", 32'(busy1), 32'd0);
        clear_q1();
        start_main(s);
        wait_done1("after_rst", 1'b0, dc);
        check_val("after_rst_done_cyc", 32'(dc - s), 32'(N1 + 1));
        check_frame1("after_rst", s);
        $display("[TB] post-reset frame: %0d plots", q1x.size());

        // Small 4x2 sweeper: exact order and done latency.
        @(posedge clock); #1 start2 = 1'b1;
        @(posedge clock); #1 s = cyc; start2 = 1'b0;
        found2 = 0;
        dc = -1;
        for (int i = 0; i < 100 && found2 == 0; i++) begin
            @(negedge clock);
            if (done2) begin
                found2 = 1;
                dc     = cyc;
            end
        end
        check_val("small_done_seen", 32'(found2), 32'd1);
        check_val("small_done_cyc",  32'(dc - s), 32'd9);
        @(negedge clock);
        check_val("small_done_width", 32'(done2), 32'd0);
        check_val("small_busy_after", 32'(busy2), 32'd0);
        check_val("small_count", 32'(q2x.size()), 32'(N2));
        for (int i = 0; i < q2x.size() && i < N2; i++) begin
            check_val($sformatf("small_x[%0d]", i), 32'(q2x[i]), 32'(i % (XM2 + 1)));
            check_val($sformatf("small_y[%0d]", i), 32'(q2y[i]), 32'(i / (XM2 + 1)));
            check_val($sformatf("small_c[%0d]", i), 32'(q2c[i]), 32'(lut(i % (XM2 + 1), i / (XM2 + 1))));
            check_val($sformatf("small_t[%0d]", i), 32'(q2t[i] - s), 32'(i + 1));
        end
        $display("[TB] small frame: %0d plots, done %0d cycles after start", q2x.size(), dc - s);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
